// File: rtl/acondicionador_botones.sv
// Button conditioner: sync + debounce five raw buttons, mode FSM, up/down auto-repeat, inactivity fallback.
// Latency: raw edge k -> registered pulse after edge k+DEB_CYCLES+2; outputs are free-running pulses, no backpressure.
module acondicionador_botones #(
    parameter int DEB_CYCLES     = 1_000_000,
    parameter int REPEAT_DELAY   = 50_000_000,
    parameter int REPEAT_RATE    = 15_000_000,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_mode,
    output logic       Arriba,
    output logic       Abajo,
    output logic       Izquierda,
    output logic       Derecha,
    output logic [2:0] configuracion,
    output logic       cambio_modo
);

    localparam int B_UP   = 0;
    localparam int B_DN   = 1;
    localparam int B_L    = 2;
    localparam int B_R    = 3;
    localparam int B_MODE = 4;

    localparam int DW      = $clog2(DEB_CYCLES);
    localparam int TMAX    = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TMW     = $clog2(TMAX + 1);
    localparam int ITW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    typedef enum logic [2:0] {
        M_NORMAL = 3'd0,
        M_TIME   = 3'd1,
        M_DATE   = 3'd2,
        M_TIMER  = 3'd4
    } mode_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT_DELAY,
        R_REPEAT
    } rep_e;

    logic [4:0]     raw;
    logic [4:0]     s1_q, s2_q;
    logic [4:0]     stable_q, stable_d;
    logic [4:0]     stable_prev_q;
    logic [DW-1:0]  deb_cnt_q [5];
    logic [DW-1:0]  deb_cnt_d [5];
    logic [4:0]     press;

    mode_e          cfg_q, cfg_d, cfg_next;
    logic           cambio_q, cambio_d;
    logic [ITW-1:0] inact_q, inact_d;
    logic           timeout_hit;
    logic           mode_chg;
    logic           dir_en;

    rep_e           rep_q, rep_d;
    logic           dir_dn_q, dir_dn_d;
    logic [TMW-1:0] timer_q, timer_d;
    logic           act_held, other_held;

    logic           arriba_q, arriba_d;
    logic           abajo_q, abajo_d;
    logic           izq_q, izq_d;
    logic           der_q, der_d;

    assign raw = {btn_mode, btn_right, btn_left, btn_down, btn_up};

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            stable_d[i]  = stable_q[i];
            deb_cnt_d[i] = '0;
            if (s2_q[i] != stable_q[i]) begin
                if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
                    stable_d[i] = s2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press = stable_q & ~stable_prev_q;

    always_comb begin
        case (cfg_q)
            M_NORMAL: cfg_next = M_TIME;
            M_TIME:   cfg_next = M_DATE;
            M_DATE:   cfg_next = M_TIMER;
            default:  cfg_next = M_NORMAL;
        endcase
    end

    // A press of any button restarts the inactivity window; mode 0 never times out.
    always_comb begin
        timeout_hit = 1'b0;
        inact_d     = '0;
        if ((TIMEOUT_CYCLES > 0) && (cfg_q != M_NORMAL) && (press == '0)) begin
            if (inact_q == ITW'(TO_LAST)) begin
                timeout_hit = 1'b1;
            end else begin
                inact_d = inact_q + 1'b1;
            end
        end
    end

    always_comb begin
        cfg_d    = cfg_q;
        cambio_d = 1'b0;
        if (press[B_MODE]) begin
            cfg_d    = cfg_next;
            cambio_d = 1'b1;
        end else if (timeout_hit) begin
            cfg_d    = M_NORMAL;
            cambio_d = 1'b1;
        end
    end

    assign mode_chg = press[B_MODE] | timeout_hit;
    assign dir_en   = (cfg_q != M_NORMAL) && !mode_chg;

    assign izq_d = dir_en & press[B_L] & ~stable_q[B_R];
    assign der_d = dir_en & press[B_R] & ~stable_q[B_L];

    assign act_held   = dir_dn_q ? stable_q[B_DN] : stable_q[B_UP];
    assign other_held = dir_dn_q ? stable_q[B_UP] : stable_q[B_DN];

    always_comb begin
        rep_d    = rep_q;
        dir_dn_d = dir_dn_q;
        timer_d  = timer_q;
        arriba_d = 1'b0;
        abajo_d  = 1'b0;
        if (!dir_en) begin
            rep_d   = R_IDLE;
            timer_d = '0;
        end else begin
            case (rep_q)
                R_IDLE: begin
                    if (press[B_UP] && !stable_q[B_DN]) begin
                        rep_d    = R_WAIT_DELAY;
                        dir_dn_d = 1'b0;
                        timer_d  = TMW'(REPEAT_DELAY);
                        arriba_d = 1'b1;
                    end else if (press[B_DN] && !stable_q[B_UP]) begin
                        rep_d    = R_WAIT_DELAY;
                        dir_dn_d = 1'b1;
                        timer_d  = TMW'(REPEAT_DELAY);
                        abajo_d  = 1'b1;
                    end
                end
                default: begin
                    // Abort wins over a due repeat so a release never yields a trailing pulse.
                    if (!act_held || other_held) begin
                        rep_d   = R_IDLE;
                        timer_d = '0;
                    end else if (timer_q == TMW'(1)) begin
                        rep_d    = R_REPEAT;
                        timer_d  = TMW'(REPEAT_RATE);
                        arriba_d = ~dir_dn_q;
                        abajo_d  = dir_dn_q;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q          <= '0;
            s2_q          <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            for (int i = 0; i < 5; i++) begin
                deb_cnt_q[i] <= '0;
            end
            cfg_q    <= M_NORMAL;
            cambio_q <= 1'b0;
            inact_q  <= '0;
            rep_q    <= R_IDLE;
            dir_dn_q <= 1'b0;
            timer_q  <= '0;
            arriba_q <= 1'b0;
            abajo_q  <= 1'b0;
            izq_q    <= 1'b0;
            der_q    <= 1'b0;
        end else begin
            s1_q          <= raw;
            s2_q          <= s1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            for (int i = 0; i < 5; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
            cfg_q    <= cfg_d;
            cambio_q <= cambio_d;
            inact_q  <= inact_d;
            rep_q    <= rep_d;
            dir_dn_q <= dir_dn_d;
            timer_q  <= timer_d;
            arriba_q <= arriba_d;
            abajo_q  <= abajo_d;
            izq_q    <= izq_d;
            der_q    <= der_d;
        end
    end

    assign Arriba        = arriba_q;
    assign Abajo         = abajo_q;
    assign Izquierda     = izq_q;
    assign Derecha       = der_q;
    assign configuracion = cfg_q;
    assign cambio_modo   = cambio_q;

endmodule

// File: tb/tb_acondicionador_botones.sv
// Directed bench for acondicionador_botones: stimulus table of button steps plus timing sequences.
module tb_acondicionador_botones;

    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RR  = 8;
    localparam int TO  = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_mode = 1'b0;
    logic       Arriba, Abajo, Izquierda, Derecha, cambio_modo;
    logic [2:0] configuracion;

    acondicionador_botones #(
        .DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_mode(btn_mode),
        .Arriba(Arriba), .Abajo(Abajo), .Izquierda(Izquierda), .Derecha(Derecha),
        .configuracion(configuracion), .cambio_modo(cambio_modo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_up = 0, n_dn = 0, n_l = 0, n_r = 0, n_chg = 0;
    int         last_chg_t = 0;
    logic [2:0] chg_cfg = 3'd0;
    int         up_t[$];

    always @(negedge clk) begin
        if (Arriba === 1'b1) begin
            n_up++;
            up_t.push_back(cyc);
        end
        if (Abajo === 1'b1) n_dn++;
        if (Izquierda === 1'b1) n_l++;
        if (Derecha === 1'b1) n_r++;
        if (cambio_modo === 1'b1) begin
            n_chg++;
            last_chg_t = cyc;
            chg_cfg    = configuracion;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic set_btn(input logic [4:0] b);
        {btn_mode, btn_up, btn_down, btn_left, btn_right} = b;
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        tick(10);
        btn_mode = 1'b0;
        tick(10);
    endtask

    function automatic int outs();
        return int'({Arriba, Abajo, Izquierda, Derecha, cambio_modo, configuracion});
    endfunction

    typedef struct {
        logic [4:0] btn;   // {mode, up, down, left, right}
        int         len;
        int         e_up, e_dn, e_l, e_r, e_chg;
        logic [2:0] cfg;
    } vec_t;

    localparam int NV = 26;
    vec_t vt[NV];
    int   mode_seq[4];
    int   b_off[4];
    int   a_off[6];

    initial begin
        int t0, c0, u0, d0, m;
        int su, sd, sl, sr, sc;

        vt[0]  = '{5'b01000, 10, 0, 0, 0, 0, 0, 3'd0};
        vt[1]  = '{5'b00000, 10, 0, 0, 0, 0, 0, 3'd0};
        vt[2]  = '{5'b00100, 10, 0, 0, 0, 0, 0, 3'd0};
        vt[3]  = '{5'b00000, 10, 0, 0, 0, 0, 0, 3'd0};
        vt[4]  = '{5'b00010, 10, 0, 0, 0, 0, 0, 3'd0};
        vt[5]  = '{5'b00000, 10, 0, 0, 0, 0, 0, 3'd0};
        vt[6]  = '{5'b00001, 10, 0, 0, 0, 0, 0, 3'd0};
        vt[7]  = '{5'b00000, 10, 0, 0, 0, 0, 0, 3'd0};
        vt[8]  = '{5'b10000, 10, 0, 0, 0, 0, 1, 3'd1};
        vt[9]  = '{5'b00000, 10, 0, 0, 0, 0, 0, 3'd1};
        vt[10] = '{5'b00010,  3, 0, 0, 0, 0, 0, 3'd1};
        vt[11] = '{5'b00000, 10, 0, 0, 0, 0, 0, 3'd1};
        vt[12] = '{5'b00010, 10, 0, 0, 1, 0, 0, 3'd1};
        vt[13] = '{5'b00000, 10, 0, 0, 0, 0, 0, 3'd1};
        vt[14] = '{5'b00001, 10, 0, 0, 0, 1, 0, 3'd1};
        vt[15] = '{5'b00000, 10, 0, 0, 0, 0, 0, 3'd1};
        vt[16] = '{5'b00011, 10, 0, 0, 0, 0, 0, 3'd1};
        vt[17] = '{5'b00000, 10, 0, 0, 0, 0, 0, 3'd1};
        vt[18] = '{5'b10000, 10, 0, 0, 0, 0, 1, 3'd2};
        vt[19] = '{5'b00000, 10, 0, 0, 0, 0, 0, 3'd2};
        vt[20] = '{5'b00100, 28, 0, 2, 0, 0, 0, 3'd2};
        vt[21] = '{5'b00000, 10, 0, 0, 0, 0, 0, 3'd2};
        vt[22] = '{5'b10001, 10, 0, 0, 0, 0, 1, 3'd4};
        vt[23] = '{5'b00000, 10, 0, 0, 0, 0, 0, 3'd4};
        vt[24] = '{5'b10000, 10, 0, 0, 0, 0, 1, 3'd0};
        vt[25] = '{5'b00000, 10, 0, 0, 0, 0, 0, 3'd0};

        mode_seq = '{1, 2, 4, 0};
        b_off    = '{DEB + 3, DEB + 3 + RD, DEB + 3 + RD + RR, DEB + 3 + RD + 2 * RR};
        a_off    = '{DEB + 3, DEB + 3 + RD, DEB + 3 + RD + RR, DEB + 3 + RD + 2 * RR,
                     DEB + 3 + RD + 3 * RR, DEB + 3 + RD + 4 * RR};

        reset = 1'b1;
        tick(3);
        check("reset_outputs", outs(), 0);
        reset = 1'b0;
        tick(2);

        // Mode cycling: latency from raw rise to cambio_modo, sequence 1,2,4,0.
        for (int i = 0; i < 4; i++) begin
            c0 = n_chg;
            t0 = cyc;
            press_mode();
            check("mode_latency", last_chg_t - t0, DEB + 3);
            check("mode_cfg", int'(chg_cfg), mode_seq[i]);
            check("mode_pulses", n_chg - c0, 1);
        end

        for (int i = 0; i < NV; i++) begin
            su = n_up; sd = n_dn; sl = n_l; sr = n_r; sc = n_chg;
            set_btn(vt[i].btn);
            tick(vt[i].len);
            n_vec++;
            if ((n_up - su) != vt[i].e_up || (n_dn - sd) != vt[i].e_dn ||
                (n_l - sl) != vt[i].e_l || (n_r - sr) != vt[i].e_r ||
                (n_chg - sc) != vt[i].e_chg || configuracion != vt[i].cfg) begin
                n_err++;
                $display("FAIL vec%0d: got up=%0d dn=%0d l=%0d r=%0d chg=%0d cfg=%0d, expected up=%0d dn=%0d l=%0d r=%0d chg=%0d cfg=%0d",
                         i, n_up - su, n_dn - sd, n_l - sl, n_r - sr, n_chg - sc, configuracion,
                         vt[i].e_up, vt[i].e_dn, vt[i].e_l, vt[i].e_r, vt[i].e_chg, vt[i].cfg);
            end
        end
        set_btn(5'b00000);

        // Mode 1: up repeating, down pressed mid-repeat stops it; releasing down adds nothing.
        press_mode();
        check("b_cfg", int'(configuracion), 1);
        up_t.delete();
        d0 = n_dn;
        t0 = cyc;
        btn_up = 1'b1;
        tick(38);
        btn_down = 1'b1;
        tick(20);
        btn_down = 1'b0;
        tick(20);
        btn_up = 1'b0;
        tick(10);
        check("b_up_count", up_t.size(), 4);
        for (int j = 0; j < 4; j++) begin
            if (j < up_t.size()) check("b_up_time", up_t[j] - t0, b_off[j]);
        end
        check("b_abajo", n_dn - d0, 0);

        // Mode 2: exact auto-repeat cadence for a 60-cycle hold.
        press_mode();
        check("a_cfg", int'(configuracion), 2);
        up_t.delete();
        t0 = cyc;
        btn_up = 1'b1;
        tick(60);
        btn_up = 1'b0;
        tick(20);
        check("a_up_count", up_t.size(), 6);
        for (int j = 0; j < 6; j++) begin
            if (j < up_t.size()) check("a_up_time", up_t[j] - t0, a_off[j]);
        end

        // Mode 4 idle: inactivity timeout returns to mode 0.
        press_mode();
        check("to_cfg4", int'(configuracion), 4);
        m  = last_chg_t;
        c0 = n_chg;
        tick(TO);
        check("to_delay", last_chg_t - m, TO);
        check("to_pulses", n_chg - c0, 1);
        check("to_cfg0", int'(configuracion), 0);

        // Reset asserted while up is auto-repeating.
        press_mode();
        u0 = n_up;
        btn_up = 1'b1;
        tick(40);
        check("c_pre_repeat", n_up - u0, 3);
        u0 = n_up;
        reset = 1'b1;
        tick(1);
        check("c_rst_out1", outs(), 0);
        tick(1);
        check("c_rst_out2", outs(), 0);
        check("c_rst_nopulse", n_up - u0, 0);
        reset = 1'b0;
        tick(20);
        check("c_post_nopulse", n_up - u0, 0);
        check("c_post_cfg", int'(configuracion), 0);
        btn_up = 1'b0;
        tick(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
